// File: rtl/tally_result_resolver.sv
// Post-poll result stage: scans every candidate slot of the tally store and resolves
// winner, maximum count, tie status and total vote count, announced with a done pulse.
module tally_result_resolver #(
  parameter int NUM_CAND = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   rd_en,
  output logic [IDX_W-1:0]       rd_addr,
  input  logic [CNT_W-1:0]       count_bin,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       winner,
  output logic [CNT_W-1:0]       max_count,
  output logic                   tie,
  output logic [CNT_W+IDX_W-1:0] total,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_FIN} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         w_win;
  logic [CNT_W-1:0]         w_max;
  logic                     w_tie;
  logic [CNT_W+IDX_W-1:0]   w_tot;

  logic [IDX_W-1:0]         nxt_win;
  logic [CNT_W-1:0]         nxt_max;
  logic                     nxt_tie;
  logic [CNT_W+IDX_W-1:0]   nxt_tot;

  assign dbg_state = state;

  // Fold the sampled count into the working results; slot 0 seeds them.
  always_comb begin
    nxt_win = w_win;
    nxt_max = w_max;
    nxt_tie = w_tie;
    nxt_tot = w_tot + {{IDX_W{1'b0}}, count_bin};
    if (idx == '0) begin
      nxt_win = '0;
      nxt_max = count_bin;
      nxt_tie = 1'b0;
    end else if (count_bin > w_max) begin
      nxt_win = idx;
      nxt_max = count_bin;
      nxt_tie = 1'b0;
    end else if (count_bin == w_max) begin
      nxt_tie = 1'b1;
    end
  end

  // Read handshake: rd_en is a one-cycle strobe with no back-pressure; count_bin
  // carries the addressed slot's count exactly one cycle later (the CMP cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      w_win     <= '0;
      w_max     <= '0;
      w_tie     <= 1'b0;
      w_tot     <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= '0;
      max_count <= '0;
      tie       <= 1'b0;
      total     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // FIN behaves like IDLE towards start so a held start chains passes back to back.
        S_IDLE, S_FIN: begin
          if (start) begin
            state   <= S_READ;
            idx     <= '0;
            w_win   <= '0;
            w_max   <= '0;
            w_tie   <= 1'b0;
            w_tot   <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_READ: begin
          state   <= S_CMP;
          rd_en   <= 1'b0;
          rd_addr <= '0;
        end
        S_CMP: begin
          w_win <= nxt_win;
          w_max <= nxt_max;
          w_tie <= nxt_tie;
          w_tot <= nxt_tot;
          if (idx == LAST) begin
            state     <= S_FIN;
            done      <= 1'b1;
            winner    <= nxt_win;
            max_count <= nxt_max;
            tie       <= nxt_tie;
            total     <= nxt_tot;
          end else begin
            state   <= S_READ;
            idx     <= idx + 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tally_result_resolver.sv
// Bench for tally_result_resolver: a slot-offset timing model plus array-based result
// reference, checked every cycle, with literal expectations for directed passes.
module tb_tally_result_resolver;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 8;
  localparam int TW = CW + IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count_bin = '0;
  logic          rd_en;
  logic [IW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic [IW-1:0] winner;
  logic [CW-1:0] max_count;
  logic          tie;
  logic [TW-1:0] total;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  tally_result_resolver #(.NUM_CAND(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .count_bin(count_bin), .busy(busy), .done(done), .winner(winner),
    .max_count(max_count), .tie(tie), .total(total), .dbg_state(dbg_state)
  );

  logic [CW-1:0] mem [N];
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            ps = -1;
  logic [IW-1:0] e_win = '0;
  logic [CW-1:0] e_max = '0;
  logic          e_tie = 1'b0;
  logic [TW-1:0] e_tot = '0;
  logic          rd_s = 1'b0;
  logic [IW-1:0] addr_s = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference result straight from the store contents.
  task automatic ref_result(output logic [IW-1:0] w, output logic [CW-1:0] m,
                            output logic t, output logic [TW-1:0] s);
    int mx = 0;
    int hits = 0;
    int sum = 0;
    int wi = 0;
    for (int i = 0; i < N; i++) if (int'(mem[i]) > mx) mx = int'(mem[i]);
    for (int i = 0; i < N; i++) begin
      if (int'(mem[i]) == mx) begin
        if (hits == 0) wi = i;
        hits++;
      end
      sum += int'(mem[i]);
    end
    w = IW'(wi);
    m = CW'(mx);
    t = (hits > 1);
    s = TW'(sum);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Tally store: valid data one cycle after rd_en, random noise otherwise.
  always @(negedge clk) begin
    rd_s   = rd_en;
    addr_s = rd_addr;
  end
  always @(posedge clk) begin
    #1;
    count_bin = rd_s ? mem[addr_s] : CW'($urandom);
  end

  always @(negedge clk) begin : cmp
    int off;
    bit act;
    bit erd;
    if (!rst_n) begin
      ps = -1;
      e_win = '0; e_max = '0; e_tie = 1'b0; e_tot = '0;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_winner", winner, 0);
      chk("rst_max", max_count, 0);
      chk("rst_tie", tie, 0);
      chk("rst_total", total, 0);
    end else begin
      off = (ps < 0) ? -1 : cyc - ps;
      act = (off >= 1) && (off <= 2*N + 1);
      erd = act && (off <= 2*N - 1) && (off % 2 == 1);
      if (off == 2*N + 1) ref_result(e_win, e_max, e_tie, e_tot);
      chk("rd_en", rd_en, erd);
      chk("rd_addr", rd_addr, erd ? (off - 1) / 2 : 0);
      chk("busy", busy, act);
      chk("done", done, off == 2*N + 1);
      chk("winner", winner, e_win);
      chk("max_count", max_count, e_max);
      chk("tie", tie, e_tie);
      chk("total", total, e_tot);
      if (start && (!act || off == 2*N + 1)) ps = cyc;
    end
  end

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 4*N + 8 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic lit(input string tag, input int w, input int m, input int t, input int s);
    chk({tag, "_winner"}, winner, w);
    chk({tag, "_max"}, max_count, m);
    chk({tag, "_tie"}, tie, t);
    chk({tag, "_total"}, total, s);
  endtask

  task automatic run_pass(input logic [CW-1:0] c [N], input bit noise);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) mem[i] = c[i];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (noise) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        start = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_pass('{8'd3, 8'd7, 8'd2, 8'd5}, 0);
    lit("p1", 1, 7, 0, 17);
    run_pass('{8'd9, 8'd4, 8'd9, 8'd1}, 0);
    lit("p2", 0, 9, 1, 23);
    run_pass('{8'd1, 8'd2, 8'd3, 8'd8}, 0);
    lit("p3", 3, 8, 0, 14);
    run_pass('{8'd0, 8'd0, 8'd0, 8'd0}, 0);
    lit("zeros", 0, 0, 1, 0);
    run_pass('{8'd255, 8'd255, 8'd255, 8'd255}, 0);
    lit("full", 0, 255, 1, 1020);

    // start re-pulsed on cycles 2 and 5 of a pass
    @(posedge clk); #1;
    mem = '{8'd4, 8'd6, 8'd6, 8'd2};
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    lit("repulse", 1, 6, 1, 18);

    // start held high across two passes
    @(posedge clk); #1;
    mem = '{8'd5, 8'd5, 8'd1, 8'd0};
    start = 1'b1;
    wait_done();
    lit("held1", 0, 5, 1, 11);
    @(posedge clk); #1;
    chk("held_rd_en", rd_en, 1);
    chk("held_rd_addr", rd_addr, 0);
    chk("held_hold_max", max_count, 5);
    mem = '{8'd10, 8'd20, 8'd30, 8'd40};
    start = 1'b0;
    wait_done();
    lit("held2", 3, 40, 0, 100);

    // reset during CMP of slot 2
    @(posedge clk); #1;
    mem = '{8'd6, 8'd1, 8'd6, 8'd2};
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_en", rd_en, 0);
    chk("async_busy", busy, 0);
    chk("async_max", max_count, 0);
    chk("async_total", total, 0);
    chk("async_winner", winner, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_pass('{8'd2, 8'd8, 8'd8, 8'd3}, 0);
    lit("post_rst", 1, 8, 1, 21);

    for (int p = 0; p < 20; p++) begin
      logic [CW-1:0] c [N];
      for (int i = 0; i < N; i++)
        c[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : CW'($urandom_range(0, 12));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_pass(c, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
